traffic_phase_arbiter: RTL

//  Demand-actuated phase scheduler for the four-way intersection. Shares green time between
//  NS and EW approaches from latched detector requests; enforces min/max green, gap extension,

---
 rtl/traffic_phase_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/traffic_phase_arbiter.sv
// traffic_phase_arbiter: demand-actuated NS/EW phase scheduler.
// Detector requests are latched as pending demand. A green phase gives way to
// pending opposing demand once it has run its minimum length and its own
// traffic has stopped extending it, or unconditionally at maximum green. Every
// green phase is followed by a fixed yellow and a fixed all-red clearance.
// Optional feature macro: EMERGENCY_PREEMPT_EN adds emg_req/emg_dir, which cut
// the opposing green short and then hold the requested green.
module traffic_phase_arbiter #(
  parameter int T_MIN_GREEN = 10,
  parameter int T_MAX_GREEN = 50,
  parameter int T_EXT       = 5,
  parameter int T_YELLOW    = 10,
  parameter int T_RED       = 5,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_ns,
  input  logic       req_ew,
  output logic [2:0] north,
  output logic [2:0] south,
  output logic [2:0] east,
  output logic [2:0] west,
  output logic [2:0] phase,
  output logic       pend_ns,
  output logic       pend_ew
`ifdef EMERGENCY_PREEMPT_EN
  ,
  input  logic       emg_req,
  input  logic       emg_dir
`endif
);

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED_1 = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALL_RED_2 = 3'd5
  } state_e;

  localparam logic [2:0] LampRed    = 3'b001;
  localparam logic [2:0] LampYellow = 3'b010;
  localparam logic [2:0] LampGreen  = 3'b100;

  localparam logic [CNT_W-1:0] MinGreenLast = CNT_W'(T_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MaxGreenLast = CNT_W'(T_MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YellowLast   = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] RedLast      = CNT_W'(T_RED - 1);
  localparam logic [CNT_W-1:0] ExtReload    = CNT_W'(T_EXT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic             pendNs_q, pendNs_d;
  logic             pendEw_q, pendEw_d;
  logic [2:0]       nsLamp_q, ewLamp_q;
  logic             emgNs, emgEw;
  logic             nsMayEnd, ewMayEnd;
  logic             stateChange;

`ifdef EMERGENCY_PREEMPT_EN
  assign emgNs = emg_req && !emg_dir;
  assign emgEw = emg_req &&  emg_dir;
`else
  assign emgNs = 1'b0;
  assign emgEw = 1'b0;
`endif

  // Lamp colour seen by the NS pair for a given state; anything else is red.
  function automatic logic [2:0] nsLampOf(input state_e s);
    case (s)
      NS_GREEN:  nsLampOf = LampGreen;
      NS_YELLOW: nsLampOf = LampYellow;
      default:   nsLampOf = LampRed;
    endcase
  endfunction

  // Lamp colour seen by the EW pair for a given state; anything else is red.
  function automatic logic [2:0] ewLampOf(input state_e s);
    case (s)
      EW_GREEN:  ewLampOf = LampGreen;
      EW_YELLOW: ewLampOf = LampYellow;
      default:   ewLampOf = LampRed;
    endcase
  endfunction

  // A green may yield once min green has elapsed and either the gap has run
  // out or max green is reached; only meaningful with opposing demand pending.
  always_comb begin
    nsMayEnd = pendEw_q && (count_q >= MinGreenLast) &&
               ((gap_q == '0) || (count_q >= MaxGreenLast));
    ewMayEnd = pendNs_q && (count_q >= MinGreenLast) &&
               ((gap_q == '0) || (count_q >= MaxGreenLast));
  end

  // Next-state decision from registered state; preemption overrides the
  // normal green-ending rules in both directions.
  always_comb begin
    state_d = state_q;
    case (state_q)
      NS_GREEN:  if (emgEw || (!emgNs && nsMayEnd)) state_d = NS_YELLOW;
      NS_YELLOW: if (count_q == YellowLast)         state_d = ALL_RED_1;
      ALL_RED_1: if (count_q == RedLast)            state_d = EW_GREEN;
      EW_GREEN:  if (emgNs || (!emgEw && ewMayEnd)) state_d = EW_YELLOW;
      EW_YELLOW: if (count_q == YellowLast)         state_d = ALL_RED_2;
      ALL_RED_2: if (count_q == RedLast)            state_d = NS_GREEN;
      default:                                      state_d = NS_GREEN;
    endcase
  end

  // Phase counter, gap timer and demand latches for the coming cycle.
  always_comb begin
    stateChange = (state_d != state_q);

    count_d = count_q;
    if (stateChange)                 count_d = '0;
    else if (count_q != MaxGreenLast) count_d = count_q + 1'b1;

    gap_d = '0;
    if (!stateChange) begin
      if ((state_q == NS_GREEN && req_ns) || (state_q == EW_GREEN && req_ew))
        gap_d = ExtReload;
      else if (gap_q != '0)
        gap_d = gap_q - 1'b1;
    end

    pendNs_d = pendNs_q;
    if (req_ns && state_q != NS_GREEN)                 pendNs_d = 1'b1;
    else if (state_d == NS_GREEN && state_q != NS_GREEN) pendNs_d = 1'b0;

    pendEw_d = pendEw_q;
    if (req_ew && state_q != EW_GREEN)                 pendEw_d = 1'b1;
    else if (state_d == EW_GREEN && state_q != EW_GREEN) pendEw_d = 1'b0;
  end

  // State register with lamps registered from the next state so they always
  // match the current state and come out of reset showing NS green.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= NS_GREEN;
      count_q  <= '0;
      gap_q    <= '0;
      pendNs_q <= 1'b0;
      pendEw_q <= 1'b0;
      nsLamp_q <= LampGreen;
      ewLamp_q <= LampRed;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      gap_q    <= gap_d;
      pendNs_q <= pendNs_d;
      pendEw_q <= pendEw_d;
      nsLamp_q <= nsLampOf(state_d);
      ewLamp_q <= ewLampOf(state_d);
    end
  end

  assign north   = nsLamp_q;
  assign south   = nsLamp_q;
  assign east    = ewLamp_q;
  assign west    = ewLamp_q;
  assign phase   = state_q;
  assign pend_ns = pendNs_q;
  assign pend_ew = pendEw_q;

endmodule
